alarme_cinto_multi: RTL and testbench

Multi-seat seatbelt warning controller: parametrised, clocked successor of the single-seat combinational alarm. It monitors ASSENTOS seats (occupancy plus belt) and the ignition. It then drives:
- a master warning light with grace period, blinking and timeout,
- a chime,
- per-seat indicators.

It sits between the cabin sensor inputs and the dashboard/chime drivers.

---
 rtl/alarme_pkg.sv | 25 ++
 rtl/alarme_cinto_multi_gerador_pisca.sv | 52 +++++
 rtl/alarme_cinto_multi.sv | 148 ++++++++++++++
 tb/tb_alarme_cinto_multi.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alarme_pkg.sv
// Shared definitions for the multi-seat seatbelt warning controller:
// FSM state encoding, default parameter values and counter sizing.
package alarme_pkg;

    // FSM states; the encoding is visible on the estado debug port.
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CARENCIA = 2'd1,
        ALERTA   = 2'd2,
        SILENCIO = 2'd3
    } estado_t;

    // Default parameter values.
    localparam int ASSENTOS_PAD     = 4;
    localparam int T_CARENCIA_PAD   = 8;
    localparam int T_PISCA_PAD      = 4;
    localparam int T_ALERTA_MAX_PAD = 64;

    // Width of a counter that runs 0..n-1. A terminal count of 1 still
    // needs one bit to exist as a signal.
    function automatic int largura_cnt(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarme_cinto_multi_gerador_pisca.sv
// Blink generator: square wave with half-period T_PISCA cycles.
// reinicia forces the entry point (phase on, counter zero) and takes
// priority over habilita, which lets the counter advance.
module gerador_pisca
    import alarme_pkg::*;
#(
    parameter int T_PISCA = T_PISCA_PAD
) (
    input  logic clk,
    input  logic reset,
    input  logic reinicia,
    input  logic habilita,
    output logic fase
);

    localparam int W_PISCA = largura_cnt(T_PISCA);
    localparam logic [W_PISCA-1:0] PISCA_FIM = W_PISCA'(T_PISCA - 1);

    logic [W_PISCA-1:0] cnt_pisca_q, cnt_pisca_d;
    logic               fase_q, fase_d;

    // Next half-period count and phase: wrap at the terminal value and flip.
    always_comb begin
        cnt_pisca_d = cnt_pisca_q;
        fase_d      = fase_q;
        if (reinicia) begin
            cnt_pisca_d = '0;
            fase_d      = 1'b1;
        end else if (habilita) begin
            if (cnt_pisca_q == PISCA_FIM) begin
                cnt_pisca_d = '0;
                fase_d      = ~fase_q;
            end else begin
                cnt_pisca_d = cnt_pisca_q + W_PISCA'(1);
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_pisca_q <= '0;
            fase_q      <= 1'b0;
        end else begin
            cnt_pisca_q <= cnt_pisca_d;
            fase_q      <= fase_d;
        end
    end

    assign fase = fase_q;

endmodule

// File: rtl/alarme_cinto_multi.sv
// Multi-seat seatbelt warning controller. Detects unbelted occupied seats
// with ignition on, runs a grace period, then a blinking light/chime alert
// that silences after a timeout and re-arms when a new seat starts violating.
module alarme_cinto_multi
    import alarme_pkg::*;
#(
    parameter int ASSENTOS     = ASSENTOS_PAD,
    parameter int T_CARENCIA   = T_CARENCIA_PAD,
    parameter int T_PISCA      = T_PISCA_PAD,
    parameter int T_ALERTA_MAX = T_ALERTA_MAX_PAD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ignicao_ligada,
    input  logic [ASSENTOS-1:0] assento_ocupado,
    input  logic [ASSENTOS-1:0] cinto_em_uso,
    output logic                luz_de_advertencia,
    output logic                sinal_sonoro,
    output logic [ASSENTOS-1:0] luz_assento,
    output logic [1:0]          estado
);

    localparam int W_CAR = largura_cnt(T_CARENCIA);
    localparam int W_ALE = largura_cnt(T_ALERTA_MAX);
    localparam logic [W_CAR-1:0] CAR_FIM = W_CAR'(T_CARENCIA - 1);
    localparam logic [W_ALE-1:0] ALE_FIM = W_ALE'(T_ALERTA_MAX - 1);

    estado_t             estado_q, estado_d;
    logic [W_CAR-1:0]    cnt_car_q, cnt_car_d;
    logic [W_ALE-1:0]    cnt_alerta_q, cnt_alerta_d;
    logic [ASSENTOS-1:0] v_prev_q;
    logic [ASSENTOS-1:0] v;
    logic                any_v;
    logic                novo;
    logic                reinicia_pisca;
    logic                fase;

    // Per-seat violation: occupied, unbelted, ignition on.
    for (genvar i = 0; i < ASSENTOS; i++) begin : g_assento
        assign v[i] = assento_ocupado[i] & ~cinto_em_uso[i] & ignicao_ligada;
    end

    assign any_v = |v;
    // A seat that violates now but did not last cycle.
    assign novo  = |(v & ~v_prev_q);

    // Next state. Ignition off forces idle; otherwise clearing beats a new
    // violation, which beats timer expiry.
    always_comb begin
        estado_d = estado_q;
        if (!ignicao_ligada) begin
            estado_d = OCIOSO;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (any_v) estado_d = CARENCIA;
                end
                CARENCIA: begin
                    // New violations do not restart the grace period.
                    if (!any_v)                  estado_d = OCIOSO;
                    else if (cnt_car_q == CAR_FIM) estado_d = ALERTA;
                end
                ALERTA: begin
                    // A new violation re-arms in place, see the counter logic.
                    if (!any_v)                       estado_d = OCIOSO;
                    else if (novo)                    estado_d = ALERTA;
                    else if (cnt_alerta_q == ALE_FIM) estado_d = SILENCIO;
                end
                SILENCIO: begin
                    if (!any_v)    estado_d = OCIOSO;
                    else if (novo) estado_d = ALERTA;
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    // The alert restarts from its entry values whenever it is entered or
    // re-armed; the blink generator and alert counter share that condition.
    assign reinicia_pisca = (estado_d == ALERTA) &&
                            ((estado_q != ALERTA) || novo);

    // Grace and alert counters: count only while staying in their state,
    // otherwise sit at zero, so they never pass their terminal values.
    always_comb begin
        cnt_car_d    = '0;
        cnt_alerta_d = '0;
        if (estado_q == CARENCIA && estado_d == CARENCIA)
            cnt_car_d = cnt_car_q + W_CAR'(1);
        if (estado_q == ALERTA && estado_d == ALERTA && !reinicia_pisca)
            cnt_alerta_d = cnt_alerta_q + W_ALE'(1);
    end

    // State, counters and the previous violation vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            cnt_car_q    <= '0;
            cnt_alerta_q <= '0;
            v_prev_q     <= '0;
        end else begin
            estado_q     <= estado_d;
            cnt_car_q    <= cnt_car_d;
            cnt_alerta_q <= cnt_alerta_d;
            v_prev_q     <= v;
        end
    end

    gerador_pisca #(
        .T_PISCA (T_PISCA)
    ) u_pisca (
        .clk      (clk),
        .reset    (reset),
        .reinicia (reinicia_pisca),
        .habilita (estado_q == ALERTA),
        .fase     (fase)
    );

    // Output decode from registered state; the blink phase only matters
    // in ALERTA, where light and chime follow it together.
    always_comb begin
        luz_de_advertencia = 1'b0;
        sinal_sonoro       = 1'b0;
        case (estado_q)
            OCIOSO: begin
                luz_de_advertencia = 1'b0;
                sinal_sonoro       = 1'b0;
            end
            CARENCIA, SILENCIO: begin
                luz_de_advertencia = 1'b1;
                sinal_sonoro       = 1'b0;
            end
            ALERTA: begin
                luz_de_advertencia = fase;
                sinal_sonoro       = fase;
            end
            default: begin
                luz_de_advertencia = 1'b0;
                sinal_sonoro       = 1'b0;
            end
        endcase
    end

    // The per-seat indicators are exactly the registered violation vector.
    assign luz_assento = v_prev_q;
    assign estado      = estado_q;

endmodule

// File: tb/tb_alarme_cinto_multi.sv
// Directed bench for alarme_cinto_multi at default parameters. Each step
// drives inputs, queues the expected post-edge outputs, then pops and
// compares after the clock edge.
module tb_alarme_cinto_multi;

    typedef struct packed {
        logic [1:0] estado;
        logic       luz;
        logic       som;
        logic [3:0] assento;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ign;
    logic [3:0] oc;
    logic [3:0] ci;
    logic       luz;
    logic       som;
    logic [3:0] luz_assento;
    logic [1:0] estado;

    exp_t  sb_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    alarme_cinto_multi #(
        .ASSENTOS     (4),
        .T_CARENCIA   (8),
        .T_PISCA      (4),
        .T_ALERTA_MAX (64)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ignicao_ligada     (ign),
        .assento_ocupado    (oc),
        .cinto_em_uso       (ci),
        .luz_de_advertencia (luz),
        .sinal_sonoro       (som),
        .luz_assento        (luz_assento),
        .estado             (estado)
    );

    function automatic exp_t ex(input logic [1:0] s, input logic l,
                                input logic so, input logic [3:0] a);
        return {s, l, so, a};
    endfunction

    task automatic passo(input logic r, input logic ig, input logic [3:0] o,
                         input logic [3:0] c, input exp_t e, input string tag);
        exp_t  esp;
        exp_t  obs;
        string t;
        reset = r;
        ign   = ig;
        oc    = o;
        ci    = c;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        obs = {estado, luz, som, luz_assento};
        esp = sb_q.pop_front();
        t   = tag_q.pop_front();
        checks++;
        assert (obs === esp) else begin
            errors++;
            $error("FAIL %s observed(est,luz,som,assento)=%b expected=%b", t, obs, esp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       rb;
        logic [3:0] ro, rc;
        logic       f;
        logic [3:0] o;
        reset = 1'b1;
        ign   = 1'b0;
        oc    = 4'b0000;
        ci    = 4'b0000;

        // Reset with random inputs.
        for (int i = 0; i < 2; i++) begin
            rb = 1'($urandom);
            ro = 4'($urandom);
            rc = 4'($urandom);
            passo(1'b1, rb, ro, rc, ex(2'd0, 1'b0, 1'b0, 4'b0000), "reset");
        end

        // Grace period: 8 cycles steady light.
        for (int j = 0; j < 8; j++)
            passo(1'b0, 1'b1, 4'b0001, 4'b0000, ex(2'd1, 1'b1, 1'b0, 4'b0001), "carencia");

        // Alert: 4 on / 4 off for 64 cycles.
        for (int a = 0; a < 64; a++) begin
            f = ((a / 4) % 2 == 0);
            passo(1'b0, 1'b1, 4'b0001, 4'b0000, ex(2'd2, f, f, 4'b0001), "alerta_pisca");
        end

        // Timeout into silence.
        for (int j = 0; j < 3; j++)
            passo(1'b0, 1'b1, 4'b0001, 4'b0000, ex(2'd3, 1'b1, 1'b0, 4'b0001), "silencio");

        // New violation re-arms from silence.
        passo(1'b0, 1'b1, 4'b0011, 4'b0000, ex(2'd2, 1'b1, 1'b1, 4'b0011), "rearme_silencio");
        for (int a = 1; a < 7; a++) begin
            f = ((a / 4) % 2 == 0);
            passo(1'b0, 1'b1, 4'b0011, 4'b0000, ex(2'd2, f, f, 4'b0011), "alerta_2");
        end

        // New violation during the off phase restarts blink and count.
        passo(1'b0, 1'b1, 4'b0111, 4'b0000, ex(2'd2, 1'b1, 1'b1, 4'b0111), "rearme_alerta");
        for (int a = 1; a < 64; a++) begin
            f = ((a / 4) % 2 == 0);
            passo(1'b0, 1'b1, 4'b0111, 4'b0000, ex(2'd2, f, f, 4'b0111), "alerta_3");
        end
        passo(1'b0, 1'b1, 4'b0111, 4'b0000, ex(2'd3, 1'b1, 1'b0, 4'b0111), "timeout_2");

        // Ignition off beats a simultaneous new violation.
        passo(1'b0, 1'b0, 4'b1111, 4'b0000, ex(2'd0, 1'b0, 1'b0, 4'b0000), "ignicao_prio");
        passo(1'b0, 1'b0, 4'b1111, 4'b0000, ex(2'd0, 1'b0, 1'b0, 4'b0000), "ignicao_ocioso");

        // Grace is not restarted by a new seat at cnt=5.
        for (int j = 0; j < 8; j++) begin
            o = (j >= 6) ? 4'b0101 : 4'b0001;
            passo(1'b0, 1'b1, o, 4'b0000, ex(2'd1, 1'b1, 1'b0, o), "carencia_fixa");
        end
        for (int a = 0; a < 3; a++)
            passo(1'b0, 1'b1, 4'b0101, 4'b0000, ex(2'd2, 1'b1, 1'b1, 4'b0101), "alerta_sem_reinicio");

        // Buckling up clears the alert.
        passo(1'b0, 1'b1, 4'b0101, 4'b0101, ex(2'd0, 1'b0, 1'b0, 4'b0000), "limpeza");

        // Reset mid-operation wins over a standing violation.
        passo(1'b0, 1'b1, 4'b0001, 4'b0000, ex(2'd1, 1'b1, 1'b0, 4'b0001), "carencia_4");
        passo(1'b0, 1'b1, 4'b0001, 4'b0000, ex(2'd1, 1'b1, 1'b0, 4'b0001), "carencia_4b");
        passo(1'b1, 1'b1, 4'b0001, 4'b0000, ex(2'd0, 1'b0, 1'b0, 4'b0000), "reset_meio");
        passo(1'b0, 1'b1, 4'b0001, 4'b0000, ex(2'd1, 1'b1, 1'b0, 4'b0001), "pos_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
